// File: rtl/mips_seq_pkg.sv
// rtl/mips_seq_pkg.sv - shared constants and types for the machine-cycle sequencer
// Purpose: machine-cycle index constants, instruction class codes and the
//          sequencer run-state enum, shared by the sequencer and its bench.
package mips_seq_pkg;

    // Machine-cycle indices presented on count_state
    localparam int ST_IDLE   = 0;
    localparam int ST_FETCH  = 1;
    localparam int ST_DECODE = 2;
    localparam int ST_EXEC   = 3;

    // Instruction classes sampled at DECODE
    localparam logic [1:0] CLASS_ALU = 2'd0;
    localparam logic [1:0] CLASS_MEM = 2'd1;
    localparam logic [1:0] CLASS_BR  = 2'd2;
    localparam logic [1:0] CLASS_JMP = 2'd3;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/cycle_perf_counter.sv
// rtl/cycle_perf_counter.sv - wrapping performance counter
// Purpose: PERF_WIDTH-bit counter that increments when inc is high and wraps
//          modulo 2**PERF_WIDTH.
// Ports:   clk, reset (sync, active-high), inc (count enable), count (value).
module cycle_perf_counter #(
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [PERF_WIDTH-1:0] count
);

    logic [PERF_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/machine_cycle_sequencer.sv
// rtl/machine_cycle_sequencer.sv - variable-length machine-cycle sequencer for the multi-cycle core
// Purpose: steps count_state through IDLE(0), FETCH(1), DECODE(2) and the
//          class-specific states up to the instruction length chosen at DECODE.
//          Supports stall hold and a stop at the next instruction boundary.
// Ports:   clk, reset (sync, active-high), enable (run / stop at boundary),
//          stall (freeze while running), instr_class (sampled at DECODE),
//          count_state (cycle index), flag (last state of instr), busy (count!=0),
//          retired_count / cycle_count (only when CYCLE_PERF_EN is defined).
// Config:  CYCLE_PERF_EN adds the retired-instruction and busy-cycle counters.
module machine_cycle_sequencer
    import mips_seq_pkg::*;
#(
    parameter int STATE_WIDTH = 3,
    parameter int LEN_ALU     = 5,
    parameter int LEN_MEM     = 5,
    parameter int LEN_BR      = 3,
    parameter int LEN_JMP     = 3,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   stall,
    input  logic [1:0]             instr_class,
    output logic [STATE_WIDTH-1:0] count_state,
    output logic                   flag,
`ifdef CYCLE_PERF_EN
    output logic [PERF_WIDTH-1:0]  retired_count,
    output logic [PERF_WIDTH-1:0]  cycle_count,
`endif
    output logic                   busy
);

    localparam logic [STATE_WIDTH-1:0] C_IDLE   = STATE_WIDTH'(ST_IDLE);
    localparam logic [STATE_WIDTH-1:0] C_FETCH  = STATE_WIDTH'(ST_FETCH);
    localparam logic [STATE_WIDTH-1:0] C_DECODE = STATE_WIDTH'(ST_DECODE);
    localparam logic [STATE_WIDTH-1:0] L_ALU    = STATE_WIDTH'(LEN_ALU);
    localparam logic [STATE_WIDTH-1:0] L_MEM    = STATE_WIDTH'(LEN_MEM);
    localparam logic [STATE_WIDTH-1:0] L_BR     = STATE_WIDTH'(LEN_BR);
    localparam logic [STATE_WIDTH-1:0] L_JMP    = STATE_WIDTH'(LEN_JMP);

    seq_state_e             state_q, state_d;
    logic [STATE_WIDTH-1:0] count_q, count_d;
    logic [STATE_WIDTH-1:0] len_q, len_d;
    logic                   flag_q, flag_d;
    logic [STATE_WIDTH-1:0] class_len;
    logic                   retire;

    always_comb begin
        class_len = L_ALU;
        case (instr_class)
            CLASS_ALU: class_len = L_ALU;
            CLASS_MEM: class_len = L_MEM;
            CLASS_BR:  class_len = L_BR;
            CLASS_JMP: class_len = L_JMP;
            default:   class_len = L_ALU;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        retire  = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                // stall has no meaning before an instruction has started
                if (enable) begin
                    state_d = SEQ_RUN;
                    count_d = C_FETCH;
                    len_d   = L_ALU;
                end
            end
            SEQ_RUN: begin
                if (!stall) begin
                    if (count_q == len_q) begin
                        retire = 1'b1;
                        if (enable) begin
                            count_d = C_FETCH;
                            len_d   = L_ALU;
                        end else begin
                            state_d = SEQ_IDLE;
                            count_d = C_IDLE;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                        // class only takes effect on the edge leaving DECODE
                        if (count_q == C_DECODE) begin
                            len_d = class_len;
                        end
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                count_d = C_IDLE;
            end
        endcase
        // registered terminal flag, derived from the values about to be loaded
        flag_d = (state_d == SEQ_RUN) && (count_d == len_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            count_q <= C_IDLE;
            len_q   <= L_ALU;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            flag_q  <= flag_d;
        end
    end

    assign count_state = count_q;
    assign flag        = flag_q;
    assign busy        = (state_q == SEQ_RUN);

`ifdef CYCLE_PERF_EN
    cycle_perf_counter #(.PERF_WIDTH(PERF_WIDTH)) u_retired_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .count (retired_count)
    );

    cycle_perf_counter #(.PERF_WIDTH(PERF_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (busy),
        .count (cycle_count)
    );
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_machine_cycle_sequencer.sv
// tb/tb_machine_cycle_sequencer.sv - self-checking bench for machine_cycle_sequencer
module tb_machine_cycle_sequencer;
    import mips_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       stall;
    logic [1:0] instr_class;
    logic [2:0] count_state;
    logic       flag;
    logic       busy;
`ifdef CYCLE_PERF_EN
    logic [31:0] retired_count;
    logic [31:0] cycle_count;
`endif

    machine_cycle_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .stall         (stall),
        .instr_class   (instr_class),
        .count_state   (count_state),
        .flag          (flag),
`ifdef CYCLE_PERF_EN
        .retired_count (retired_count),
        .cycle_count   (cycle_count),
`endif
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       st;
        logic [1:0] cls;
        logic [2:0] cnt;
        logic       flg;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks;
    int   failures;

    task automatic add(input logic r, input logic e, input logic s,
                       input logic [1:0] c, input int n, input logic f);
        vec_t v;
        v.rst = r; v.en = e; v.st = s; v.cls = c;
        v.cnt = 3'(n); v.flg = f; v.bsy = (n != 0);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s, input logic [1:0] c);
        @(negedge clk);
        reset = r; enable = e; stall = s; instr_class = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        vec_t ex;
        checks = 0;
        failures = 0;
        reset = 1'b1; enable = 1'b0; stall = 1'b0; instr_class = CLASS_ALU;

        // reset, with reset winning over enable
        add(1,0,0,0,0,0); add(1,1,0,0,0,0);
        // back-to-back ALU instructions
        add(0,1,0,0,1,0); add(0,1,0,0,2,0); add(0,1,0,0,3,0);
        add(0,1,0,0,4,0); add(0,1,0,0,5,1); add(0,1,0,0,1,0);
        // BR then MEM; class changes after DECODE are ignored
        add(0,1,0,0,2,0); add(0,1,0,2,3,1); add(0,1,0,0,1,0);
        add(0,1,0,0,2,0); add(0,1,0,1,3,0); add(0,1,0,2,4,0);
        add(0,1,0,3,5,1); add(0,1,0,0,1,0);
        // JMP
        add(0,1,0,0,2,0); add(0,1,0,3,3,1); add(0,1,0,0,1,0);
        // stall at EXEC and at terminal state
        add(0,1,0,0,2,0); add(0,1,0,0,3,0); add(0,1,1,0,3,0); add(0,1,1,0,3,0);
        add(0,1,0,0,4,0); add(0,1,0,0,5,1); add(0,1,1,0,5,1); add(0,1,1,0,5,1);
        add(0,1,0,0,1,0);
        // stall at DECODE must not load the class
        add(0,1,0,0,2,0); add(0,1,1,2,2,0); add(0,1,0,0,3,0);
        add(0,1,0,0,4,0); add(0,1,0,0,5,1); add(0,1,0,0,1,0);
        // enable dropped at DECODE: finish, then IDLE; stall ignored in IDLE
        add(0,1,0,0,2,0); add(0,0,0,0,3,0); add(0,0,0,0,4,0); add(0,0,0,0,5,1);
        add(0,0,0,0,0,0); add(0,0,0,0,0,0); add(0,0,1,0,0,0); add(0,1,1,0,1,0);
        // enable dropped then re-asserted mid-instruction
        add(0,0,0,0,2,0); add(0,1,0,0,3,0); add(0,1,0,0,4,0); add(0,1,0,0,5,1);
        add(0,1,0,0,1,0);
        // reset mid-instruction, restart, then BR with enable low
        add(0,1,0,0,2,0); add(0,1,0,0,3,0); add(0,1,0,0,4,0); add(1,1,0,0,0,0);
        add(0,1,0,0,1,0); add(0,0,0,0,2,0); add(0,0,0,2,3,1); add(0,0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            reset = v.rst; enable = v.en; stall = v.st; instr_class = v.cls;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            check("count_state", i, longint'(count_state), longint'(ex.cnt));
            check("flag", i, longint'(flag), longint'(ex.flg));
            check("busy", i, longint'(busy), longint'(ex.bsy));
        end

`ifdef CYCLE_PERF_EN
        // 3 ALU instructions with one stall cycle, then stop
        step(1,0,0,0);
        check("perf_retired_reset", 0, longint'(retired_count), 0);
        check("perf_cycle_reset", 0, longint'(cycle_count), 0);
        step(0,1,0,0); step(0,1,0,0);
        step(0,1,1,0);
        for (int k = 0; k < 12; k++) step(0,1,0,0);
        check("perf_pre_stop_count", 0, longint'(count_state), 4);
        step(0,0,0,0); step(0,0,0,0);
        check("perf_idle", 0, longint'(count_state), 0);
        check("perf_retired", 0, longint'(retired_count), 3);
        check("perf_cycles", 0, longint'(cycle_count), 16);
        step(0,0,0,0);
        check("perf_cycles_idle_hold", 0, longint'(cycle_count), 16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
